// File: rtl/ramrwp_clr_pkg.sv
// Shared types and constants for the clearable single-clock RAM.
package ramrwp_clr_pkg;

  // Controller state: sweeping INITVAL into the array, or serving user traffic.
  typedef enum logic [0:0] {
    StClear = 1'b0,
    StRun   = 1'b1
  } ramrwp_state_e;

  localparam int unsigned PipeMin = 1;
  localparam int unsigned PipeMax = 2;

  // Legal read-latency check used at elaboration.
  function automatic bit pipe_ok(input int unsigned p);
    return (p >= PipeMin) && (p <= PipeMax);
  endfunction

endpackage

// File: rtl/ramrwp_core.sv
// Storage array: byte-masked write port and registered read port, no reset.
// Callers must keep both addresses below DEPTH.
module ramrwp_core #(
  parameter int unsigned ADDRBIT = 9,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BYTEW   = 8
) (
  input  logic                     clk,
  input  logic                     wen,
  input  logic [ADDRBIT-1:0]       waddr,
  input  logic [WIDTH/BYTEW-1:0]   wbe,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ren,
  input  logic [ADDRBIT-1:0]       raddr,
  output logic [WIDTH-1:0]         rdata
);

  localparam int unsigned NBE = WIDTH / BYTEW;
  // Index width that exactly covers the array; upper address bits are zero by contract.
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // Masked write and read-before-write registered read on the same edge.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int k = 0; k < NBE; k++) begin
        if (wbe[k]) mem[waddr[AW-1:0]][k*BYTEW +: BYTEW] <= wdata[k*BYTEW +: BYTEW];
      end
    end
    if (ren) rdata <= mem[raddr[AW-1:0]];
  end

endmodule

// File: rtl/ramrwp_clr.sv
// Single-clock RAM with byte enables, 1/2-cycle read latency, optional
// same-address write-through, and a hardware clear sweep after reset or clr.
// The read-data output is named dout because "do" is a reserved word.
module ramrwp_clr
  import ramrwp_clr_pkg::*;
#(
  parameter int unsigned       ADDRBIT = 9,
  parameter int unsigned       DEPTH   = 512,
  parameter int unsigned       WIDTH   = 32,
  parameter int unsigned       BYTEW   = 8,
  parameter int unsigned       PIPE    = 1,
  parameter int unsigned       BYPASS  = 1,
  parameter logic [WIDTH-1:0]  INITVAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    rdy,
  input  logic [ADDRBIT-1:0]      wa,
  input  logic                    we,
  input  logic [WIDTH/BYTEW-1:0]  be,
  input  logic [WIDTH-1:0]        di,
  input  logic [ADDRBIT-1:0]      ra,
  input  logic                    re,
  output logic [WIDTH-1:0]        dout,
  output logic                    dov
);

  localparam int unsigned          NBE      = WIDTH / BYTEW;
  localparam logic [ADDRBIT-1:0]   LastAddr = ADDRBIT'(DEPTH - 1);
  localparam logic [ADDRBIT:0]     DepthExt = (ADDRBIT + 1)'(DEPTH);

  if (WIDTH % BYTEW != 0) begin : g_err_width
    $error("ramrwp_clr: WIDTH must be a multiple of BYTEW");
  end
  if (!pipe_ok(PIPE)) begin : g_err_pipe
    $error("ramrwp_clr: PIPE must be 1 or 2");
  end
  if (64'(DEPTH) > (64'd1 << ADDRBIT)) begin : g_err_depth
    $error("ramrwp_clr: DEPTH exceeds 2**ADDRBIT");
  end

  ramrwp_state_e      state_q, state_d;
  logic [ADDRBIT-1:0] cnt_q, cnt_d;

  logic sweeping, wr_in_range, rd_in_range, wr_acc, rd_acc;

  assign sweeping    = (state_q == StClear);
  assign rdy         = (state_q == StRun);
  assign wr_in_range = ({1'b0, wa} < DepthExt);
  assign rd_in_range = ({1'b0, ra} < DepthExt);
  assign wr_acc      = rdy & we & wr_in_range;
  assign rd_acc      = rdy & re;

  // Sweep/run controller; clr restarts the sweep from address 0 in either state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LastAddr) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic                   core_wen;
  logic [ADDRBIT-1:0]     core_waddr;
  logic [NBE-1:0]         core_wbe;
  logic [WIDTH-1:0]       core_wdata, core_rdata;

  // Write port belongs to the sweep while clearing, otherwise to the user.
  always_comb begin
    core_wen   = wr_acc;
    core_waddr = wa;
    core_wbe   = be;
    core_wdata = di;
    if (sweeping) begin
      core_wen   = 1'b1;
      core_waddr = cnt_q;
      core_wbe   = '1;
      core_wdata = INITVAL;
    end
  end

  ramrwp_core #(
    .ADDRBIT (ADDRBIT),
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .BYTEW   (BYTEW)
  ) u_core (
    .clk   (clk),
    .wen   (core_wen),
    .waddr (core_waddr),
    .wbe   (core_wbe),
    .wdata (core_wdata),
    .ren   (rd_acc & rd_in_range),
    .raddr (ra),
    .rdata (core_rdata)
  );

  logic             s1_vld_q, s1_oor_q;
  logic [NBE-1:0]   s1_hit_q;
  logic [WIDTH-1:0] s1_byp_q, s1_data;

  // Stage-1 side info captured with the array read: range flag and collision lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_oor_q <= 1'b0;
      s1_hit_q <= '0;
      s1_byp_q <= '0;
    end else begin
      s1_vld_q <= rd_acc;
      if (rd_acc) begin
        s1_oor_q <= ~rd_in_range;
        s1_hit_q <= ((BYPASS != 0) && wr_acc && (ra == wa)) ? be : '0;
        s1_byp_q <= di;
      end
    end
  end

  // Merge colliding write lanes over the old word; out-of-range reads return INITVAL.
  always_comb begin
    s1_data = core_rdata;
    for (int k = 0; k < NBE; k++) begin
      if (s1_hit_q[k]) s1_data[k*BYTEW +: BYTEW] = s1_byp_q[k*BYTEW +: BYTEW];
    end
    if (s1_oor_q) s1_data = INITVAL;
  end

  if (PIPE == 2) begin : g_pipe2
    logic [WIDTH-1:0] dout_q;
    logic             dov_q;

    // Plain second register stage; holds data when no read completes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        dov_q  <= 1'b0;
      end else begin
        dov_q <= s1_vld_q;
        if (s1_vld_q) dout_q <= s1_data;
      end
    end

    assign dout = dout_q;
    assign dov  = dov_q;
  end else begin : g_pipe1
    // The array output register has no reset, so force zero until the first read lands.
    logic zero_q;

    // Track whether any read has landed since reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         zero_q <= 1'b1;
      else if (rd_acc) zero_q <= 1'b0;
    end

    assign dout = zero_q ? '0 : s1_data;
    assign dov  = s1_vld_q;
  end

endmodule

// File: tb/tb_ramrwp_clr.sv
// Scoreboard bench for ramrwp_clr: two instances share stimulus,
// one with PIPE=2/BYPASS=1 and one with PIPE=1/BYPASS=0.
module tb_ramrwp_clr;

  localparam int unsigned DP = 16;
  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        we  = 1'b0;
  logic        re  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [4:0]  ra  = '0;
  logic [3:0]  be  = '0;
  logic [31:0] di  = '0;

  logic        rdy1, rdy2, dov1, dov2;
  logic [31:0] do1, do2;

  int cyc  = 0;
  int nvec = 0;
  int nbad = 0;
  int n;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        e1, e2;
  logic [31:0] model [DP];
  logic [31:0] ev;

  ramrwp_clr #(
    .ADDRBIT (5), .DEPTH (DP), .WIDTH (32), .BYTEW (8),
    .PIPE (1), .BYPASS (0), .INITVAL (IV)
  ) dut1 (
    .clk (clk), .rst (rst), .clr (clr), .rdy (rdy1),
    .wa (wa), .we (we), .be (be), .di (di),
    .ra (ra), .re (re), .dout (do1), .dov (dov1)
  );

  ramrwp_clr #(
    .ADDRBIT (5), .DEPTH (DP), .WIDTH (32), .BYTEW (8),
    .PIPE (2), .BYPASS (1), .INITVAL (IV)
  ) dut2 (
    .clk (clk), .rst (rst), .clr (clr), .rdy (rdy2),
    .wa (wa), .we (we), .be (be), .di (di),
    .ra (ra), .re (re), .dout (do2), .dov (dov2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  // One cycle of stimulus; expectations (x1 for PIPE=1, x2 for PIPE=2) queued if accepted.
  task automatic step(input logic w, input logic [4:0] aw, input logic [3:0] b,
                      input logic [31:0] d, input logic r, input logic [4:0] ar,
                      input logic [31:0] x1, input logic [31:0] x2);
    we = w; wa = aw; be = b; di = d; re = r; ra = ar;
    if (r && rdy1) begin
      q1.push_back('{x1, cyc + 1});
      q2.push_back('{x2, cyc + 2});
    end
    if (w && rdy1 && (aw < DP)) model[aw[3:0]] = merge(model[aw[3:0]], d, b);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wait_rdy(output int cnt);
    cnt = 0;
    while (!rdy1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DP; i++) model[i] = IV;
  endtask

  // Monitor for the PIPE=1 instance.
  always @(negedge clk) begin
    if (dov1) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected dov", 32'(dov1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut1 rdata", do1, e1.d);
        check("dut1 latency", 32'(cyc), 32'(e1.due));
      end
    end
  end

  // Monitor for the PIPE=2 instance.
  always @(negedge clk) begin
    if (dov2) begin
      if (q2.size() == 0) begin
        check("dut2 unexpected dov", 32'(dov2), 32'd0);
      end else begin
        e2 = q2.pop_front();
        check("dut2 rdata", do2, e2.d);
        check("dut2 latency", 32'(cyc), 32'(e2.due));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    #1;
    check("reset rdy1", 32'(rdy1), 32'd0);
    check("reset rdy2", 32'(rdy2), 32'd0);
    check("reset dov1", 32'(dov1), 32'd0);
    check("reset dov2", 32'(dov2), 32'd0);
    check("reset do1", do1, 32'd0);
    check("reset do2", do2, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // T1: sweep length and cleared contents
    wait_rdy(n);
    check("T1 sweep cycles", 32'(n), 32'd16);
    check("T1 rdy2", 32'(rdy2), 32'd1);
    for (int i = 0; i < DP; i++) step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'(i), IV, IV);
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd20, IV, IV);

    // T2: byte-lane masking
    step(1'b1, 5'd3, 4'hF, 32'h11223344, 1'b0, 5'd0, '0, '0);
    step(1'b1, 5'd3, 4'b0101, 32'hFFFFFFFF, 1'b0, 5'd0, '0, '0);
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd3, 32'h11FF33FF, 32'h11FF33FF);

    // T3: same-cycle collision, then a plain re-read
    step(1'b1, 5'd5, 4'hF, 32'h00000000, 1'b0, 5'd0, '0, '0);
    step(1'b1, 5'd5, 4'b1100, 32'hDEADBEEF, 1'b1, 5'd5, 32'h00000000, 32'hDEAD0000);
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd5, 32'hDEAD0000, 32'hDEAD0000);

    // Out-of-range write has no effect
    step(1'b1, 5'd17, 4'hF, 32'h12345678, 1'b0, 5'd0, '0, '0);
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd17, IV, IV);
    step(1'b1, 5'd6, 4'h0, 32'h12345678, 1'b0, 5'd0, '0, '0);
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd6, IV, IV);

    // T4: clear request in RUN; traffic during the sweep is ignored
    step(1'b1, 5'd7, 4'hF, 32'h77777777, 1'b0, 5'd0, '0, '0);
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd7, 32'h77777777, 32'h77777777);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("T4 rdy1 low after clr", 32'(rdy1), 32'd0);
    check("T4 rdy2 low after clr", 32'(rdy2), 32'd0);
    n = 0;
    while (!rdy1 && n < 200) begin
      step(1'b1, 5'd8, 4'hF, 32'h88888888, 1'b1, 5'd8, '0, '0);
      n++;
    end
    check("T4 sweep cycles", 32'(n), 32'd16);
    model_clear();
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd7, IV, IV);
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd8, IV, IV);

    // T5: full-throughput read+write on rotating addresses
    for (int i = 0; i < 64; i++) begin
      ev = model[(i + 8) % DP];
      step(1'b1, 5'(i % DP), 4'(i % 16), 32'h01010101 * i ^ 32'h5A00C300, 1'b1,
           5'((i + 8) % DP), ev, ev);
    end
    repeat (3) @(negedge clk);

    // T6: reset with reads in flight
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd3, model[3], model[3]);
    re = 1'b1; ra = 5'd4;
    q1.push_back('{model[4], cyc + 1});
    q2.push_back('{model[4], cyc + 2});
    @(posedge clk);
    #1;
    re  = 1'b0;
    rst = 1'b1;
    #1;
    check("T6 dov1 dropped", 32'(dov1), 32'd0);
    check("T6 dov2 dropped", 32'(dov2), 32'd0);
    check("T6 do1 zero", do1, 32'd0);
    check("T6 do2 zero", do2, 32'd0);
    q1.delete();
    q2.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_rdy(n);
    check("T6 sweep cycles", 32'(n), 32'd16);
    model_clear();
    step(1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd3, IV, IV);
    repeat (4) @(negedge clk);
    check("q1 drained", 32'(q1.size()), 32'd0);
    check("q2 drained", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
